uart_rx: RTL and testbench

Oversampling UART receiver for the UART-ALU system: the receive-side counterpart of the UART transmitter, sharing the same frame format (start, LSB-first data, optional parity, stop). It deserialises the serial line into `DATA_WIDTH`-bit words and checks parity and stop bits. It presents each good byte to the system controller as a one-cycle `DATA_VLD` pulse. `CLK` is the oversampling clock, running at `DIV_RATIO` × baud rate.

---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - oversampling UART receiver.
//
// Deserialises a start / LSB-first data / optional parity / stop frame into a
// DATA_WIDTH-bit word. CLK runs at DIV_RATIO x baud. Each bit is decided by a
// 3-sample majority vote around the bit centre.
//
// Parameters
//   DATA_WIDTH  payload bits per frame (>= 2)
//   DIV_RATIO   CLK cycles per bit (even, >= 4)
//
// Ports
//   CLK       in   oversampling clock, rising edge
//   RST       in   asynchronous active-low reset
//   RX_IN     in   serial line, idles high
//   PAR_EN    in   1 = frame carries a parity bit (latched at start)
//   PAR_TYP   in   0 = even, 1 = odd parity (latched at start)
//   P_DATA    out  last good received word
//   DATA_VLD  out  one-cycle pulse, P_DATA updated
//   PAR_ERR   out  one-cycle pulse, parity mismatch
//   STP_ERR   out  one-cycle pulse, stop bit sampled low
//
// Build option
//   UART_RX_SYNC_EN  when defined, RX_IN goes through a two-flop synchroniser
//                    (reset high) and all latencies grow by 2 cycles. When
//                    undefined, RX_IN must already be synchronous to CLK.
// ---------------------------------------------------------------------------

// Majority-of-three bit sampler. Captures the line at the three centre
// edges of a bit and votes; the vote is consumed at the last edge of the bit.
module uart_rx_sampler #(
  parameter int DIV_RATIO = 8,
  parameter int CW        = 3
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          rx,
  input  logic [CW-1:0] edge_cnt,
  output logic          bit_val
);
  localparam logic [CW-1:0] S0 = CW'(DIV_RATIO/2 - 1);
  localparam logic [CW-1:0] S1 = CW'(DIV_RATIO/2);

  logic s0, s1, s2;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (edge_cnt == S0) s0 <= rx;
      if (edge_cnt == S1) s1 <= rx;
    end
  end

  generate
    if (DIV_RATIO/2 + 1 == DIV_RATIO - 1) begin : g_live_third
      // DIV_RATIO == 4: third sample lands on the decision edge itself,
      // so vote with the live line value.
      assign s2 = rx;
    end else begin : g_reg_third
      localparam logic [CW-1:0] S2 = CW'(DIV_RATIO/2 + 1);
      logic s2_q;
      always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)            s2_q <= 1'b1;
        else if (edge_cnt == S2) s2_q <= rx;
      end
      assign s2 = s2_q;
    end
  endgenerate

  assign bit_val = (s0 & s1) | (s0 & s2) | (s1 & s2);
endmodule

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_RATIO  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  localparam int CW = $clog2(DIV_RATIO);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] EC_LAST  = CW'(DIV_RATIO - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                  rx;
  logic [2:0]            state;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_l, par_typ_l, par_bad;
  logic                  bit_val;
  logic                  bit_end;
  logic                  par_exp;

  // ---- line input ---------------------------------------------------------
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  uart_rx_sampler #(.DIV_RATIO(DIV_RATIO), .CW(CW)) u_smp (
    .gclk     (CLK),
    .grst_n   (RST),
    .rx       (rx),
    .edge_cnt (edge_cnt),
    .bit_val  (bit_val)
  );

  assign bit_end = (edge_cnt == EC_LAST);
  assign par_exp = (^shift) ^ par_typ_l;

  // ---- bit timing ---------------------------------------------------------
  // The IDLE cycle that sees the falling edge is edge 0 of the start bit,
  // hence the jump straight to 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (state == IDLE) begin
      edge_cnt <= rx ? '0 : CW'(1);
    end else begin
      edge_cnt <= bit_end ? '0 : edge_cnt + CW'(1);
    end
  end

  // ---- frame FSM and datapath ---------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      par_bad   <= 1'b0;
      P_DATA    <= '0;
      DATA_VLD  <= 1'b0;
      PAR_ERR   <= 1'b0;
      STP_ERR   <= 1'b0;
    end else begin
      DATA_VLD <= 1'b0;
      PAR_ERR  <= 1'b0;
      STP_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx) begin
            state     <= START;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            par_bad   <= 1'b0;
          end
        end
        START: begin
          // A start bit that votes high was a line glitch.
          if (bit_end) state <= bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift <= {bit_val, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (bit_val != par_exp) begin
              PAR_ERR <= 1'b1;
              par_bad <= 1'b1;
            end
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            if (!bit_val) begin
              STP_ERR <= 1'b1;
            end else if (!par_bad) begin
              P_DATA   <= shift;
              DATA_VLD <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, parity, stop errors, glitch
// rejection, mid-frame reset and back-to-back frames.
module tb_uart_rx;
  localparam int DIV = 8;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VLD, PAR_ERR, STP_ERR;

  uart_rx #(.DATA_WIDTH(8), .DIV_RATIO(DIV)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VLD(DATA_VLD), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  // pulse monitor: ecnt is the index of the next rising edge
  int ecnt = 0;
  int vld_n = 0, perr_n = 0, serr_n = 0;
  int vld_e = -1, perr_e = -1, serr_e = -1;
  always @(posedge CLK) begin
    #1;
    if (DATA_VLD) begin vld_n++;  vld_e  = ecnt; end
    if (PAR_ERR)  begin perr_n++; perr_e = ecnt; end
    if (STP_ERR)  begin serr_n++; serr_e = ecnt; end
    ecnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame, one bit per DIV cycles. Optional single-cycle low
  // glitch at cycle gcyc of frame bit gbit; stops early after ncyc cycles.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic sbit,
                            input int gbit, input int gcyc, input int ncyc,
                            output int t0);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin bits[9] = pbit; bits[10] = sbit; nb = 11; end
    else    begin bits[9] = sbit; nb = 10; end
    t0 = 0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < DIV; c++) begin
        if (b*DIV + c < ncyc) begin
          @(negedge CLK);
          if (b == 0 && c == 0) begin
            PAR_EN = pe; PAR_TYP = pt; t0 = ecnt;
          end
          RX_IN = (b == gbit && c == gcyc) ? ~bits[b] : bits[b];
        end
      end
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (P_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_pdata: got %h want 00", P_DATA); end
    n_cmp++; if ({DATA_VLD, PAR_ERR, STP_ERR} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {DATA_VLD, PAR_ERR, STP_ERR}); end
    RST = 1'b1;
    idle(4);
  endtask

  task automatic test_basic;
    int t0, v0, p0, s0;
    v0 = vld_n; p0 = perr_n; s0 = serr_n;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (vld_n - v0 !== 1) begin n_bad++; $display("FAIL a5_vld_count: got %0d want 1", vld_n - v0); end
    n_cmp++; if (vld_e - t0 + 1 !== 80 + LAT) begin n_bad++; $display("FAIL a5_vld_cycle: got %0d want %0d", vld_e - t0 + 1, 80 + LAT); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_bad++; $display("FAIL a5_pdata: got %h want a5", P_DATA); end
    n_cmp++; if ((perr_n - p0) + (serr_n - s0) !== 0) begin n_bad++; $display("FAIL a5_no_err: got %0d err pulses want 0", (perr_n - p0) + (serr_n - s0)); end
  endtask

  task automatic test_parity;
    int t0, v0, p0;
    // 0x3C: four ones, even parity bit 0
    v0 = vld_n; p0 = perr_n;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (vld_e - t0 + 1 !== 88 + LAT || vld_n - v0 !== 1) begin n_bad++; $display("FAIL par_even_vld: got cycle %0d n %0d want cycle %0d n 1", vld_e - t0 + 1, vld_n - v0, 88 + LAT); end
    n_cmp++; if (P_DATA !== 8'h3C || perr_n !== p0) begin n_bad++; $display("FAIL par_even_data: got %h perr %0d want 3c perr 0", P_DATA, perr_n - p0); end
    // same frame, wrong parity bit
    v0 = vld_n; p0 = perr_n;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (perr_n - p0 !== 1 || perr_e - t0 + 1 !== 80 + LAT) begin n_bad++; $display("FAIL par_even_err: got n %0d cycle %0d want n 1 cycle %0d", perr_n - p0, perr_e - t0 + 1, 80 + LAT); end
    n_cmp++; if (vld_n !== v0) begin n_bad++; $display("FAIL par_err_novld: got %0d want 0", vld_n - v0); end
    // 0x07 odd parity: three ones, parity bit 0
    v0 = vld_n;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (vld_n - v0 !== 1 || P_DATA !== 8'h07) begin n_bad++; $display("FAIL par_odd: got n %0d data %h want n 1 data 07", vld_n - v0, P_DATA); end
    // 0xF0 even parity with bit 1: error, P_DATA keeps 0x07
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (P_DATA !== 8'h07) begin n_bad++; $display("FAIL par_err_hold: got %h want 07", P_DATA); end
  endtask

  task automatic test_back_to_back;
    int ta, tb, v0, s0;
    v0 = vld_n; s0 = serr_n;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 1000, ta);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1000, tb);
    idle(6);
    n_cmp++; if (serr_n - s0 !== 1 || serr_e - ta + 1 !== 80 + LAT) begin n_bad++; $display("FAIL stp_err: got n %0d cycle %0d want n 1 cycle %0d", serr_n - s0, serr_e - ta + 1, 80 + LAT); end
    n_cmp++; if (tb - ta !== 80) begin n_bad++; $display("FAIL b2b_gap: got %0d want 80", tb - ta); end
    n_cmp++; if (vld_n - v0 !== 1 || vld_e - tb + 1 !== 80 + LAT) begin n_bad++; $display("FAIL b2b_vld: got n %0d cycle %0d want n 1 cycle %0d", vld_n - v0, vld_e - tb + 1, 80 + LAT); end
    n_cmp++; if (P_DATA !== 8'h55) begin n_bad++; $display("FAIL b2b_data: got %h want 55", P_DATA); end
  endtask

  task automatic test_glitch;
    int t0, v0, p0, s0;
    v0 = vld_n; p0 = perr_n; s0 = serr_n;
    PAR_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge CLK); RX_IN = 1'b0; end
    idle(24);
    n_cmp++; if ((vld_n - v0) + (perr_n - p0) + (serr_n - s0) !== 0) begin n_bad++; $display("FAIL idle_glitch: got %0d pulses want 0", (vld_n - v0) + (perr_n - p0) + (serr_n - s0)); end
    // FSM must be back in IDLE: a clean frame right after is received
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (vld_n - v0 !== 1 || P_DATA !== 8'h5A || vld_e - t0 + 1 !== 80 + LAT) begin n_bad++; $display("FAIL glitch_recover: got n %0d data %h want n 1 data 5a", vld_n - v0, P_DATA); end
    // single low cycle at sample edge 4 of data bit 3
    v0 = vld_n;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4, 1000, t0);
    idle(6);
    n_cmp++; if (vld_n - v0 !== 1 || P_DATA !== 8'hFF) begin n_bad++; $display("FAIL data_glitch: got n %0d data %h want n 1 data ff", vld_n - v0, P_DATA); end
  endtask

  task automatic test_mid_reset;
    int t0, v0, p0, s0;
    v0 = vld_n; p0 = perr_n; s0 = serr_n;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 40, t0);
    @(negedge CLK);
    RST = 1'b0; RX_IN = 1'b1;
    #1;
    n_cmp++; if ({P_DATA, DATA_VLD, PAR_ERR, STP_ERR} !== 11'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 000", {P_DATA, DATA_VLD, PAR_ERR, STP_ERR}); end
    idle(3);
    RST = 1'b1;
    idle(60);
    n_cmp++; if ((vld_n - v0) + (perr_n - p0) + (serr_n - s0) !== 0) begin n_bad++; $display("FAIL midrst_no_pulse: got %0d want 0", (vld_n - v0) + (perr_n - p0) + (serr_n - s0)); end
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1000, t0);
    idle(6);
    n_cmp++; if (vld_n - v0 !== 1 || P_DATA !== 8'h34) begin n_bad++; $display("FAIL midrst_recover: got n %0d data %h want n 1 data 34", vld_n - v0, P_DATA); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_glitch;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
